// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing the ram_full access port between two requesters.
// Optional WAIT watchdog compiled in with RAM_ARB_TIMEOUT_EN (abort after TIMEOUT cycles, err=1).
module ram_arbiter #(
    parameter int ADDR_W  = 17,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_err,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_err,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_done,
    output logic              busy,
    output logic              grant_id
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_WAIT, S_RESP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_last;
    logic              r_grant;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              w_take;
    logic              w_pick;
    logic              w_expire;
    logic              w_finish;
    logic [DATA_W-1:0] w_rd_val;

    // On a tie the port that did not win last time is served.
    assign w_take   = r0_req | r1_req;
    assign w_pick   = (r0_req && r1_req) ? ~r_last : r1_req;
    assign w_finish = (r_state == S_WAIT) && (mem_done || w_expire);
    assign w_rd_val = mem_done ? mem_data_out : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_take) w_next = S_SETUP;
            S_SETUP:  w_next = S_STROBE;
            S_STROBE: w_next = S_WAIT;
            S_WAIT:   if (mem_done || w_expire) w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last   <= 1'b1;
            r_grant  <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (r_state == S_IDLE && w_take) begin
                r_grant <= w_pick;
                r_last  <= w_pick;
                r_we    <= w_pick ? r1_we    : r0_we;
                r_addr  <= w_pick ? r1_addr  : r0_addr;
                r_wdata <= w_pick ? r1_wdata : r0_wdata;
            end
            // Writes leave the requester's read data untouched.
            if (w_finish && !r_we) begin
                if (r_grant) r_rdata1 <= w_rd_val;
                else         r_rdata0 <= w_rd_val;
            end
        end
    end

`ifdef RAM_ARB_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == S_STROBE)    r_cnt <= '0;
            else if (r_state == S_WAIT) r_cnt <= r_cnt + 8'd1;
            // A done arriving on the expiry cycle still counts as success.
            if (w_finish) r_err <= ~mem_done;
        end
    end

    assign w_expire = (r_state == S_WAIT) && (r_cnt == 8'(TIMEOUT - 1));
    assign r0_err   = r0_ack && r_err;
    assign r1_err   = r1_ack && r_err;
`else
    assign w_expire = 1'b0;
    assign r0_err   = 1'b0;
    assign r1_err   = 1'b0;
`endif

    assign mem_re      = (r_state == S_STROBE) && !r_we;
    assign mem_we      = (r_state == S_STROBE) &&  r_we;
    assign mem_addr    = r_addr;
    assign mem_data_in = r_wdata;
    assign busy        = (r_state != S_IDLE);
    assign grant_id    = r_grant;
    assign r0_ack      = (r_state == S_RESP) && !r_grant;
    assign r1_ack      = (r_state == S_RESP) &&  r_grant;
    assign r0_rdata    = r_rdata0;
    assign r1_rdata    = r_rdata1;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: transaction-level model (grant order, access timing, memory contents)
// driven by randomized requesters and a randomized ram_full responder.
module tb_ram_arbiter;
    localparam int AW  = 17;
    localparam int DW  = 16;
    localparam int TMO = 15;
`ifdef RAM_ARB_TIMEOUT_EN
    localparam int TMO_LIM = TMO;
`else
    localparam int TMO_LIM = 1 << 30;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rq    [2];
    logic          rwe   [2];
    logic [AW-1:0] raddr [2];
    logic [DW-1:0] rwd   [2];
    logic          mem_done;
    logic [DW-1:0] mem_data_out;
    logic          r0_ack, r1_ack, r0_err, r1_err;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic          mem_re, mem_we, busy, grant_id;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .r0_req(rq[0]), .r0_we(rwe[0]), .r0_addr(raddr[0]), .r0_wdata(rwd[0]),
        .r0_ack(r0_ack), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(rq[1]), .r1_we(rwe[1]), .r1_addr(raddr[1]), .r1_wdata(rwd[1]),
        .r1_ack(r1_ack), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .mem_done(mem_done),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h cyc_time=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: one outstanding access, described by its timestamps.
    int            cyc, t_free, t_strobe, t_done, t_ack, m_port, force_k, max_gap, obs_ack_cyc;
    bit            m_act, m_we, m_err, m_last, m_gid, wd_en, obs_err;
    logic [AW-1:0] m_addr, m_maddr;
    logic [DW-1:0] m_wd, m_mdin, m_rd;
    logic [DW-1:0] exp_rd [2];
    int            served [2], gap [2], obs_cnt [2], obs_stb;
    bit            waitack [2], gen_en [2];
    int            obs_log [$];
    logic [DW-1:0] mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] memrd(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return a[15:0] ^ 16'hA5C3;
    endfunction

    task automatic model_reset();
        m_act = 0; m_last = 1; m_gid = 0; m_maddr = '0; m_mdin = '0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        t_free = cyc + 1; t_ack = -1; t_done = -1; t_strobe = -1;
        waitack[0] = 0; waitack[1] = 0;
    endtask

    task automatic step();
        bit pr0, pr1, st, ak, inwin;
        bit skip [2];
        int k, p;
        pr0 = rq[0];
        pr1 = rq[1];
        @(posedge clk); #1;
        cyc++;
        skip[0] = 0; skip[1] = 0;
        if (!m_act && cyc >= t_free && (pr0 || pr1)) begin
            p = (pr0 && pr1) ? (m_last ? 0 : 1) : (pr1 ? 1 : 0);
            m_act = 1; m_port = p; m_we = rwe[p]; m_addr = raddr[p]; m_wd = rwd[p];
            m_last = (p == 1); m_gid = (p == 1); m_maddr = raddr[p]; m_mdin = rwd[p];
            t_strobe = cyc + 1; t_done = -1; t_ack = -1;
        end
        st = m_act && (cyc == t_strobe);
        if (mem_re || mem_we) obs_stb++;
        check_eq("mem_re", 32'(mem_re), 32'(st && !m_we));
        check_eq("mem_we", 32'(mem_we), 32'(st && m_we));
        check_eq("busy", 32'(busy), 32'(m_act));
        check_eq("grant_id", 32'(grant_id), 32'(m_gid));
        check_eq("mem_addr", 32'(mem_addr), 32'(m_maddr));
        check_eq("mem_data_in", 32'(mem_data_in), 32'(m_mdin));
        if (st) begin
            k = int'($urandom_range(4, 1));
`ifdef RAM_ARB_TIMEOUT_EN
            if ($urandom % 8 == 0) k = int'($urandom_range(TMO + 3, TMO - 1));
`endif
            if (force_k > 0) k = force_k;
            if (k <= TMO_LIM) begin
                t_done = cyc + k; t_ack = cyc + k + 1; m_err = 0;
                m_rd = m_we ? '0 : memrd(m_addr);
            end else begin
                t_done = -1; t_ack = cyc + TMO + 1; m_err = 1; m_rd = '0;
            end
            if (m_we) mem[m_addr] = m_wd;
        end
        ak = m_act && (cyc == t_ack);
        if (r0_ack || r1_ack) begin
            obs_ack_cyc = cyc; obs_err = r0_err | r1_err;
            obs_log.push_back(r1_ack ? 1 : 0);
            if (r0_ack) obs_cnt[0]++;
            if (r1_ack) obs_cnt[1]++;
        end
        check_eq("r0_ack", 32'(r0_ack), 32'(ak && m_port == 0));
        check_eq("r1_ack", 32'(r1_ack), 32'(ak && m_port == 1));
        if (ak && !m_we) exp_rd[m_port] = m_rd;
        check_eq("r0_rdata", 32'(r0_rdata), 32'(exp_rd[0]));
        check_eq("r1_rdata", 32'(r1_rdata), 32'(exp_rd[1]));
        check_eq("r0_err", 32'(r0_err), 32'(ak && m_port == 0 && m_err));
        check_eq("r1_err", 32'(r1_err), 32'(ak && m_port == 1 && m_err));
        if (ak) begin
            m_act = 0; t_free = cyc + 2; served[m_port]++;
            rq[m_port] = 0; waitack[m_port] = 0; skip[m_port] = 1;
            gap[m_port] = int'($urandom % 32'(max_gap + 1));
        end
        // ram_full side: done must stay low through WAIT except on the chosen cycle.
        inwin = m_act && (t_ack > 0) && (cyc > t_strobe) && (cyc < t_ack);
        if (m_act && cyc == t_done) begin
            mem_done = 1; mem_data_out = m_rd;
        end else begin
            mem_done = inwin ? 1'b0 : ($urandom % 4 == 0);
            mem_data_out = DW'($urandom);
        end
        for (int q = 0; q < 2; q++) begin
            if (gen_en[q] && !skip[q]) begin
                if (rq[q]) begin
                    if (wd_en && m_act && m_port == q) begin
                        if ($urandom % 8 == 0) begin rq[q] = 0; waitack[q] = 1; end
                    end else if (wd_en && $urandom % 16 == 0) begin
                        rq[q] = 0; gap[q] = int'($urandom % 3);
                    end
                end else if (!waitack[q]) begin
                    if (gap[q] > 0) gap[q]--;
                    else begin
                        rq[q] = 1; rwe[q] = $urandom % 2 == 1;
                        raddr[q] = AW'($urandom) & 17'h1001F; rwd[q] = DW'($urandom);
                    end
                end
            end
        end
    endtask

    task automatic run_until(input int p, input int target, input int limit, input string tag);
        int n = 0;
        while (served[p] < target && n < limit) begin step(); n++; end
        if (served[p] < target) check_eq(tag, 32'(served[p]), 32'(target));
    endtask

    initial begin
        int c0, n, s0;
        for (int i = 0; i < 2; i++) begin
            rq[i] = 0; rwe[i] = 0; raddr[i] = '0; rwd[i] = '0; gen_en[i] = 0;
            served[i] = 0; gap[i] = 0; obs_cnt[i] = 0; waitack[i] = 0;
        end
        mem_done = 0; mem_data_out = '0; force_k = 0; max_gap = 0; wd_en = 0;
        cyc = 0; obs_ack_cyc = -1000; obs_err = 0; obs_stb = 0;

        #3 rst = 1;
        #1;
        check_eq("rst_mem_re", 32'(mem_re), 0);
        check_eq("rst_mem_we", 32'(mem_we), 0);
        check_eq("rst_mem_addr", 32'(mem_addr), 0);
        check_eq("rst_mem_din", 32'(mem_data_in), 0);
        check_eq("rst_r0_ack", 32'(r0_ack), 0);
        check_eq("rst_r1_ack", 32'(r1_ack), 0);
        check_eq("rst_r0_rdata", 32'(r0_rdata), 0);
        check_eq("rst_r1_rdata", 32'(r1_rdata), 0);
        check_eq("rst_r0_err", 32'(r0_err), 0);
        check_eq("rst_r1_err", 32'(r1_err), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_grant_id", 32'(grant_id), 0);
        repeat (2) @(negedge clk);
        rst = 0;
        model_reset();

        // Single read, done on the first WAIT cycle.
        mem[17'h00010] = 16'h1234; force_k = 1; s0 = obs_stb;
        rq[0] = 1; rwe[0] = 0; raddr[0] = 17'h00010; rwd[0] = 16'h0000;
        c0 = cyc;
        run_until(0, served[0] + 1, 30, "rd_wait");
        check_eq("rd_latency", 32'(obs_ack_cyc - c0), 32'd4);
        check_eq("rd_data", 32'(r0_rdata), 32'h1234);
        check_eq("rd_strobes", 32'(obs_stb - s0), 32'd1);

        // Single write on the upper bank.
        force_k = 2; n = obs_cnt[1]; s0 = obs_stb;
        rq[1] = 1; rwe[1] = 1; raddr[1] = 17'h10005; rwd[1] = 16'hBEEF;
        run_until(1, served[1] + 1, 30, "wr_wait");
        check_eq("wr_ack_cnt", 32'(obs_cnt[1] - n), 32'd1);
        check_eq("wr_strobes", 32'(obs_stb - s0), 32'd1);
        check_eq("wr_addr", 32'(mem_addr), 32'h10005);
        check_eq("wr_din", 32'(mem_data_in), 32'hBEEF);
        check_eq("wr_rdata", 32'(r1_rdata), 32'h0);

        // Contention: both requesters re-request immediately.
        force_k = 0; max_gap = 0; wd_en = 0; gen_en[0] = 1; gen_en[1] = 1;
        obs_log.delete();
        n = 0;
        while (obs_log.size() < 8 && n < 200) begin step(); n++; end
        gen_en[0] = 0; gen_en[1] = 0;
        if (obs_log.size() < 8) check_eq("rr_count", 32'(obs_log.size()), 32'd8);
        else for (int i = 0; i < 8; i++) check_eq($sformatf("rr_order%0d", i), 32'(obs_log[i]), 32'(i % 2));
        n = 0;
        while ((rq[0] || rq[1] || m_act) && n < 100) begin step(); n++; end
        if (n >= 100) check_eq("rr_drain", 32'(n), 32'd0);

`ifdef RAM_ARB_TIMEOUT_EN
        // Watchdog: no done at all, then done exactly on the last allowed WAIT cycle.
        mem[17'h00123] = 16'h7777;
        force_k = TMO + 5; rq[0] = 1; rwe[0] = 0; raddr[0] = 17'h00123; c0 = cyc;
        run_until(0, served[0] + 1, 60, "tmo_wait");
        check_eq("tmo_latency", 32'(obs_ack_cyc - c0), 32'(3 + TMO));
        check_eq("tmo_err", 32'(obs_err), 32'd1);
        check_eq("tmo_rdata", 32'(r0_rdata), 32'h0);
        repeat (2) step();
        force_k = TMO; rq[0] = 1; c0 = cyc;
        run_until(0, served[0] + 1, 60, "late_wait");
        check_eq("late_latency", 32'(obs_ack_cyc - c0), 32'(3 + TMO));
        check_eq("late_err", 32'(obs_err), 32'd0);
        check_eq("late_rdata", 32'(r0_rdata), 32'h7777);
        repeat (2) step();
`endif

        // Reset while WAITing: strobes/busy drop at once, the access is lost.
        force_k = 100; rq[0] = 1; rwe[0] = 0; raddr[0] = 17'h00ABC;
        n = 0;
        while (!(m_act && t_strobe > 0 && cyc >= t_strobe + 2) && n < 20) begin step(); n++; end
        if (n >= 20) check_eq("mid_reach_wait", 32'(n), 32'd0);
        #2 rst = 1;
        #1;
        check_eq("mid_mem_re", 32'(mem_re), 0);
        check_eq("mid_mem_we", 32'(mem_we), 0);
        check_eq("mid_busy", 32'(busy), 0);
        check_eq("mid_r0_ack", 32'(r0_ack), 0);
        rq[0] = 0; mem_done = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        model_reset();
        n = obs_cnt[0] + obs_cnt[1];
        repeat (6) step();
        check_eq("mid_no_ack", 32'(obs_cnt[0] + obs_cnt[1] - n), 32'd0);
        force_k = 2; rq[1] = 1; rwe[1] = 0; raddr[1] = 17'h10011; n = obs_cnt[1];
        run_until(1, served[1] + 1, 30, "mid_r1_wait");
        check_eq("mid_r1_served", 32'(obs_cnt[1] - n), 32'd1);
        check_eq("mid_r1_rdata", 32'(r1_rdata), 32'(memrd(17'h10011)));

        // Randomized traffic with gaps, withdrawals and drops after grant.
        force_k = 0; max_gap = 3; wd_en = 1; gen_en[0] = 1; gen_en[1] = 1;
        repeat (3000) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
